rca_pipelined_addsub: RTL

- Parametrised, pipelined successor to the combinational 16-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry slices, each followed by a register, with a valid/ready handshake on both sides.
- Used in datapaths where a full-width ripple chain misses timing. Also the configurable adder instance for batch adder-generation experiments.

---
 rtl/rca_pipelined_addsub.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rca_pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES registered slices,
// with skewed operand/sum registers so every bit of a transaction leaves in the same cycle.
module rca_pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             cin;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  // Mode is folded into B and the slice-0 carry here, so it travels with the data.
  assign b_cond  = i_sub ? ~i_add_term2 : i_add_term2;
  assign cin     = i_sub | i_carry;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;
    localparam int REM  = WIDTH - DONE;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_in;
    logic             c_out;
    logic             v_in;
    logic [DONE-1:0]  sum_nxt;
    logic [DONE-1:0]  sum_p;
    logic             carry_p;
    logic             vld_p;

    if (k == 0) begin : g_src
      assign a_sl    = i_add_term1[CHUNK-1:0];
      assign b_sl    = b_cond[CHUNK-1:0];
      assign c_in    = cin;
      assign v_in    = i_valid;
      assign sum_nxt = s_sl;
    end else begin : g_src
      assign a_sl    = g_stage[k-1].g_ops.opa_p[CHUNK-1:0];
      assign b_sl    = g_stage[k-1].g_ops.opb_p[CHUNK-1:0];
      assign c_in    = g_stage[k-1].carry_p;
      assign v_in    = g_stage[k-1].vld_p;
      assign sum_nxt = {s_sl, g_stage[k-1].sum_p};
    end

    always_comb begin
      logic c;
      c    = c_in;
      s_sl = '0;
      for (int i = 0; i < CHUNK; i++) begin
        {c, s_sl[i]} = full_add(a_sl[i], b_sl[i], c);
      end
      c_out = c;
    end

    // Stage k boundary: finished sum bits, slice carry and valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_p   <= 1'b0;
        carry_p <= 1'b0;
        sum_p   <= '0;
      end else if (en) begin
        vld_p   <= v_in;
        carry_p <= c_out;
        sum_p   <= sum_nxt;
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] opa_p;
      logic [REM-1:0] opb_p;
      logic [REM-1:0] opa_nxt;
      logic [REM-1:0] opb_nxt;

      if (k == 0) begin : g_rest
        assign opa_nxt = i_add_term1[WIDTH-1:CHUNK];
        assign opb_nxt = b_cond[WIDTH-1:CHUNK];
      end else begin : g_rest
        assign opa_nxt = g_stage[k-1].g_ops.opa_p[REM+CHUNK-1:CHUNK];
        assign opb_nxt = g_stage[k-1].g_ops.opb_p[REM+CHUNK-1:CHUNK];
      end

      // Stage k boundary: operand bits still waiting for their slice.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          opa_p <= '0;
          opb_p <= '0;
        end else if (en) begin
          opa_p <= opa_nxt;
          opb_p <= opb_nxt;
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic ovf_p;
      // Carry into the MSB is recovered from its sum bit: a ^ b ^ s.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          ovf_p <= 1'b0;
        end else if (en) begin
          ovf_p <= (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1]) ^ c_out;
        end
      end
    end
  end

  assign o_valid    = g_stage[STAGES-1].vld_p;
  assign o_result   = {g_stage[STAGES-1].carry_p, g_stage[STAGES-1].sum_p};
  assign o_overflow = g_stage[STAGES-1].g_ovf.ovf_p;

endmodule
